// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 4167;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned FRAME_BITS       = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a registered head word and a registered not-empty flag.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // Full when pointers differ only in the wrap bit; a same-cycle pop frees a slot for the push.
  assign o_full_c     = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {AW{1'b0}}};
  assign w_pop        = i_pop & r_valid;
  assign w_push       = i_push & (~o_full_c | w_pop);
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);

  // Next head comes from the write port when that slot is only being filled this cycle.
  always_comb begin
    w_head_nxt = r_data;
    if (w_rd_ptr_nxt != w_wr_ptr_nxt) begin
      if (w_rd_ptr_nxt == r_wr_ptr) w_head_nxt = i_data;
      else                          w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_data   <= w_head_nxt;
      r_valid  <= (w_rd_ptr_nxt != w_wr_ptr_nxt);
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: input synchroniser, bit timer, framing FSM, sticky error flags and RX FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
  output logic       irq,
  output logic       busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned IW = $clog2(FRAME_BITS);
  // Loaded with N-1 so expiry (count == 0) lands N cycles after the load.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  rx_state_e             r_state;
  rx_state_e             w_state_nxt;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic                  r_rx_prev;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_bit_idx;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  r_irq;
  logic                  r_busy;

  logic w_fall;
  logic w_expire;
  logic w_load_half;
  logic w_load_full;
  logic w_shift;
  logic w_stop_smp;
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_ovr_set;
  logic w_ferr_set;
  logic w_fifo_valid;

  assign w_fall   = r_rx_prev & ~r_rx_s;
  assign w_expire = (r_state != IDLE) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_nxt = START;
      START:   if (w_expire) w_state_nxt = r_rx_s ? IDLE : DATA;
      DATA:    if (w_expire && (r_bit_idx == IW'(FRAME_BITS - 1))) w_state_nxt = STOP;
      STOP:    if (w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_shift     = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      IDLE:  w_load_half = w_fall;
      START: w_load_full = w_expire & ~r_rx_s;
      DATA: begin
        w_shift     = w_expire;
        w_load_full = w_expire;
      end
      STOP:  w_stop_smp = w_expire;
      default: ;
    endcase
  end

  // Synchroniser, bit timer and data path; sync flops preset high to match an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_busy    <= (w_state_nxt != IDLE);
      if (w_load_half)       r_cnt <= HALF_LOAD;
      else if (w_load_full)  r_cnt <= FULL_LOAD;
      else if (r_cnt != '0)  r_cnt <= r_cnt - CW'(1);
      if (w_shift) begin
        r_shift   <= {r_rx_s, r_shift[FRAME_BITS-1:1]};
        r_bit_idx <= r_bit_idx + IW'(1);
      end else if (w_load_full) begin
        r_bit_idx <= '0;
      end
    end
  end

  assign w_pop      = rx_ready & w_fifo_valid;
  assign w_push_req = w_stop_smp & r_rx_s;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovr_set  = w_push_req & w_full & ~w_pop;
  assign w_ferr_set = w_stop_smp & ~r_rx_s;

  // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_ferr_set)   r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
      if (w_ovr_set)    r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
      r_irq <= w_fifo_valid | r_frame_err | r_overrun;
    end
  end

  uart_rx_fifo #(
    .WIDTH (FRAME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_push),
    .i_data   (r_shift),
    .i_pop    (w_pop),
    .o_data   (rx_data),
    .o_valid  (w_fifo_valid),
    .o_full_c (w_full)
  );

  assign rx_valid  = w_fifo_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign irq       = r_irq;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: bit-accurate serial driver, byte scoreboard, table of frames plus corner sequences.
module tb_uart_rx_ctrl;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int M_NONE    = 0;
  localparam int M_LAT     = 1;
  localparam int M_FERR    = 2;
  localparam int M_POPSAME = 3;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       irq;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         mode;
    int         pops;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
    .irq       (irq),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
  endtask

  task automatic pop_check(input string nm);
    logic [7:0] exp;
    check({nm, "_valid"}, 32'(rx_valid), 32'd1);
    if (q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got=%0h expected=none", nm, rx_data);
    end else begin
      exp = q.pop_front();
      check({nm, "_data"}, 32'(rx_data), 32'(exp));
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // One full frame, LSB first; mode adds cycle-exact checks around the stop-bit sample.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int mode);
    logic [9:0] f;
    logic [7:0] exp;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      rx = f[i / CPB];
      @(negedge clk);
      if (mode == M_LAT && i + 1 == 154) check("lat_valid_pre", 32'(rx_valid), 32'd0);
      if (mode == M_LAT && i + 1 == 155) begin
        check("lat_valid_post", 32'(rx_valid), 32'd1);
        check("lat_data", 32'(rx_data), 32'(b));
        check("lat_busy_done", 32'(busy), 32'd0);
      end
      if (mode == M_FERR && i + 1 == 154) check("ferr_pre", 32'(frame_err), 32'd0);
      if (mode == M_FERR && i + 1 == 155) begin
        check("ferr_post", 32'(frame_err), 32'd1);
        check("irq_lag", 32'(irq), 32'd0);
      end
      if (mode == M_FERR && i + 1 == 156) check("irq_follow", 32'(irq), 32'd1);
      if (mode == M_POPSAME && i + 1 == 154) begin
        check("popsame_valid", 32'(rx_valid), 32'd1);
        exp = q.pop_front();
        check("popsame_data", 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
      end
      if (mode == M_POPSAME && i + 1 == 155) rx_ready = 1'b0;
    end
    rx = 1'b1;
    if (stop_bit && q.size() < DEPTH) q.push_back(b);
  endtask

  initial begin
    vecs[0] = '{8'h3D, 1'b1, M_LAT,  1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h0F, 1'b1, M_NONE, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, M_NONE, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, M_NONE, 0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, M_NONE, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h11, 1'b1, M_NONE, 4, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte with latency check, then four-deep fill and overrun on the fifth.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].mode);
      check("vec_valid", 32'(rx_valid), 32'(vecs[v].exp_valid));
      check("vec_ferr", 32'(frame_err), 32'(vecs[v].exp_ferr));
      check("vec_ovr", 32'(overrun), 32'(vecs[v].exp_ovr));
      for (int p = 0; p < vecs[v].pops; p++) pop_check("vec_pop");
      if (vecs[v].pops > 0) check("vec_drained", 32'(rx_valid), 32'd0);
    end

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    @(negedge clk);
    check("irq_idle", 32'(irq), 32'd0);

    // Short low glitch: START rejects it and busy drops again.
    rx = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) check("glitch_busy", 32'(busy), 32'd1);
    end
    rx = 1'b1;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("glitch_idle", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    check("glitch_nopush", 32'(rx_valid), 32'd0);

    // Framing error, irq one cycle later, then cleared.
    send_frame(8'h55, 1'b0, M_FERR);
    check("ferr_nopush", 32'(rx_valid), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ferr_cleared", 32'(frame_err), 32'd0);
    @(negedge clk);
    check("ferr_irq_clr", 32'(irq), 32'd0);

    // Full FIFO with pop on the stop-sample edge: push still lands, no overrun.
    send_frame(8'h21, 1'b1, M_NONE);
    send_frame(8'h43, 1'b1, M_NONE);
    send_frame(8'h65, 1'b1, M_NONE);
    send_frame(8'h87, 1'b1, M_NONE);
    send_frame(8'h99, 1'b1, M_POPSAME);
    check("popsame_ovr", 32'(overrun), 32'd0);
    for (int p = 0; p < DEPTH; p++) pop_check("popsame_pop");
    check("popsame_drained", 32'(rx_valid), 32'd0);

    // Reset in the middle of data bit 4, then a clean frame.
    send_frame(8'hA0, 1'b0, M_NONE);
    send_frame(8'h5A, 1'b1, M_NONE);
    begin
      logic [9:0] f;
      f = {1'b1, 8'hC3, 1'b0};
      for (int i = 0; i < 5 * CPB + CPB / 2; i++) begin
        rx = f[i / CPB];
        @(negedge clk);
      end
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(rx_data), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    q.delete();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (CPB * 6) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_empty", 32'(rx_valid), 32'd0);
    send_frame(8'h7E, 1'b1, M_NONE);
    pop_check("post_rst_pop");
    check("post_rst_drained", 32'(rx_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
